result_window_stats: RTL
========================

// Module: result_window_stats
// PURPOSE
//   Downstream consumer of the signed adder result stream. Gathers samples into
//   fixed windows of 2**LOG2_WIN samples and reports sum, arithmetic mean, min
//   and max per window. Output uses a valid/ready handshake.
//   Window start is aligned to an external sync pulse, normally the counter-wrap
//   flag of the upstream stage.
// PARAMETERS
//   DATA_W    32  sample width, two's-complement signed
//   LOG2_WIN  4   log2 of window length; WIN = 2**LOG2_WIN, LOG2_WIN >= 1
//   SUM_W     DATA_W+LOG2_WIN  derived (localparam); sum width, overflow impossible
// PORTS
//   clk        in   1         rising-edge clock, single clock domain
//   rst        in   1         synchronous, active-high reset
//   in_data    in   DATA_W    signed sample
//   in_valid   in   1         sample accepted on every clk edge where high (no in_ready)
//   sync       in   1         window-align pulse; sampled every clk edge
//   out_ready  in   1         consumer accepts result when out_valid && out_ready
//   out_valid  out  1         result registers hold an unconsumed window
//   out_sum    out  SUM_W     signed sum of window
//   out_mean   out  DATA_W    out_sum >>> LOG2_WIN (arithmetic, floor toward -inf)
//   out_min    out  DATA_W    signed minimum of window
//   out_max    out  DATA_W    signed maximum of window
//   busy       out  1         high in ACCUM state
//   overrun    out  1         sticky: completed window overwrote an unconsumed result
// BEHAVIOUR
//   Reset: state=IDLE, sample count=0, accumulators=0. All outputs 0.
//   FSM IDLE: samples ignored. Move to ACCUM on an edge with sync=1.
//     If in_valid=1 on that edge, the sample becomes sample 0 of the window.
//   FSM ACCUM: each accepted sample does acc+=sext(in_data), updates min/max, count++.
//     First sample of a window loads min=max=in_data (no compare against stale data).
//   Window close: on the edge that accepts sample WIN-1:
//     - out_* registers load the final values, including that sample.
//     - out_valid=1 from the next cycle. Latency is 1 clk from the last sample edge.
//     - Accumulators and count restart with no gap; a sample on the very next edge is sample 0.
//   sync while in ACCUM: the partial window is discarded. count and accumulators restart.
//     The sample on the sync edge, if valid, becomes sample 0.
//     sync has priority over window close: no result is produced on that edge.
//   Handshake: out_valid clears on an edge with out_ready=1, unless a window closes on the same edge.
//     Simultaneous close and out_ready: load the new result, out_valid stays 1, no overrun.
//     Close with out_valid=1 and out_ready=0: newest wins (registers overwritten), overrun<=1.
//   overrun is cleared only by rst. out_* registers are stable while out_valid && !out_ready.
//   rst mid-window or mid-handshake: all state dropped, back to IDLE, next window waits for sync.
//   Width rules:
//     - Sum is sign-extended to SUM_W before adding; it cannot wrap.
//     - out_mean is the low DATA_W bits of the arithmetic shift, which is exact because |mean| <= max|sample|.
// STRUCTURE
//   Shared package window_stats_pkg:
//     - FSM encoding ST_IDLE=1'b0, ST_ACCUM=1'b1
//     - function for SUM_W derivation
//   One sub-module, signed_minmax: DATA_W-wide running min/max with a first-sample load input.
//     Instantiated once. Count, accumulator, FSM and output registers stay in the top.
// TESTING  (DATA_W=32, LOG2_WIN=2 unless noted)
//   1. rst, then sync with samples 5,-3,10,-8 back-to-back, out_ready=1
//      -> out_valid one clk after -8; sum=4, mean=1, min=-8, max=10; overrun=0.
//   2. Samples -1,-1,-1,-2 -> sum=-5, mean=-2 (floor), min=-2, max=-1.
//      All 0x7FFFFFFF with LOG2_WIN=4 -> sum=0x7FFFFFFF*16, no wrap.
//   3. in_valid before any sync -> ignored, busy=0.
//      sync after 2 samples of a window, then 4 samples of 1 -> one result, sum=4.
//   4. out_ready=0, two full windows (sums 4 then 8) -> overrun=1, out_sum=8.
//      Then out_ready=1 -> out_valid drops next clk; overrun stays 1 until rst.
//   5. out_ready=1 exactly on a window-close edge with a pending result
//      -> new result loaded, out_valid stays 1, overrun=0.
//   6. rst asserted after sample 2 and while out_valid=1
//      -> all outputs 0, IDLE; the samples that follow are ignored until sync.

Source files
------------

// File: rtl/window_stats_pkg.sv
// Shared definitions for the result window statistics block.
//   - state_t     : two-state FSM encoding (idle / accumulating)
//   - calc_sum_w  : width of a window sum that can never wrap
package window_stats_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // A sum of 2**log2_win samples of data_w bits needs log2_win extra bits.
    function automatic int calc_sum_w(input int data_w, input int log2_win);
        return data_w + log2_win;
    endfunction

endpackage

// File: rtl/signed_minmax.sv
// Running signed minimum / maximum tracker.
//   clk, rst          : clock, synchronous active-high reset (clears to 0)
//   en                : a sample is being accepted this edge
//   first             : this sample opens a window; load it as both min and max
//   din               : signed sample
//   nxt_min, nxt_max  : min/max including din (combinational), what the
//                       registers take on an enabled edge
module signed_minmax
    import window_stats_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] nxt_min,
    output logic signed [DATA_W-1:0] nxt_max
);

    logic signed [DATA_W-1:0] cur_min;
    logic signed [DATA_W-1:0] cur_max;

    // On the first sample the held values are stale and must not be compared.
    always_comb begin
        nxt_min = cur_min;
        nxt_max = cur_max;
        if (first) begin
            nxt_min = din;
            nxt_max = din;
        end else begin
            if (din < cur_min) nxt_min = din;
            if (din > cur_max) nxt_max = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_min <= '0;
            cur_max <= '0;
        end else if (en) begin
            cur_min <= nxt_min;
            cur_max <= nxt_max;
        end
    end

endmodule

// File: rtl/result_window_stats.sv
// Per-window statistics over a signed sample stream.
// Collects 2**LOG2_WIN samples per window (window start aligned to sync) and
// publishes sum, floor mean, min and max through a valid/ready register stage.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : signed sample, taken on every edge with in_valid=1 (no backpressure)
//   sync       : window-align pulse; restarts the window, its sample is sample 0
//   out_ready  : consumer accepts the result when out_valid && out_ready
//   out_valid  : result registers hold an unconsumed window
//   out_sum / out_mean / out_min / out_max : window results
//   busy       : FSM is accumulating
//   overrun    : sticky, a completed window replaced an unconsumed result
module result_window_stats
    import window_stats_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int LOG2_WIN = 4,
    localparam int SUM_W    = calc_sum_w(DATA_W, LOG2_WIN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     sync,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [SUM_W-1:0]  out_sum,
    output logic signed [DATA_W-1:0] out_mean,
    output logic signed [DATA_W-1:0] out_min,
    output logic signed [DATA_W-1:0] out_max,
    output logic                     busy,
    output logic                     overrun
);

    state_t state, state_nxt;

    logic        [LOG2_WIN-1:0] cnt;
    logic signed [SUM_W-1:0]    acc;
    logic signed [SUM_W-1:0]    din_ext;
    logic signed [SUM_W-1:0]    sum_nxt;
    logic                       take;
    logic                       first;
    logic                       close;
    logic signed [DATA_W-1:0]   min_nxt;
    logic signed [DATA_W-1:0]   max_nxt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sync) state_nxt = ST_ACCUM;
            ST_ACCUM: state_nxt = ST_ACCUM;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_ACCUM);
    end

    // ---------------- datapath ----------------
    assign din_ext = {{LOG2_WIN{in_data[DATA_W-1]}}, in_data};

    // sync restarts the window in either state, so the running sum is
    // discarded and the sync-edge sample starts from zero.
    assign take    = in_valid && (sync || state == ST_ACCUM);
    assign first   = sync || (cnt == '0);
    assign sum_nxt = (sync ? '0 : acc) + din_ext;
    // sync wins over window close; cnt all-ones means this is sample WIN-1.
    assign close   = (state == ST_ACCUM) && !sync && in_valid && (&cnt);

    signed_minmax #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk     (clk),
        .rst     (rst),
        .en      (take),
        .first   (first),
        .din     (in_data),
        .nxt_min (min_nxt),
        .nxt_max (max_nxt)
    );

    // acc is held at zero whenever cnt is zero, so a fresh window needs no
    // separate clear path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (sync) begin
            cnt <= in_valid ? LOG2_WIN'(1) : '0;
            acc <= in_valid ? din_ext : '0;
        end else if (take) begin
            if (close) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= sum_nxt;
            end
        end
    end

    // ---------------- result stage ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_mean  <= '0;
            out_min   <= '0;
            out_max   <= '0;
            overrun   <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= sum_nxt;
            // |mean| never exceeds max|sample|, so truncation is exact.
            out_mean  <= DATA_W'(sum_nxt >>> LOG2_WIN);
            out_min   <= min_nxt;
            out_max   <= max_nxt;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
